// File: rtl/axonerve_kvs_kernel_core.sv
// Ternary key-value store core: a command FIFO feeds a single-cycle CAM-style
// lookup/modify engine over ENTRIES slots of {key, mask, priority, value}.
// Every executed command produces one registered O_ACK with flags and data.
module axonerve_kvs_kernel_core #(
  parameter int          ENTRIES    = 16,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic         I_CLK,
  input  logic         I_XRST,
  output logic [31:0]  O_VERSION,
  output logic         O_READY,
  output logic         O_WAIT,
  output logic         O_ACK,
  output logic         O_ENT_ERR,
  output logic         O_SINGLE_HIT,
  output logic         O_MULTIL_HIT,
  output logic [127:0] O_KEY_DAT,
  output logic [127:0] O_EKEY_MSK,
  output logic [6:0]   O_KEY_PRI,
  output logic [31:0]  O_KEY_VALUE,
  output logic         O_CMD_EMPTY,
  output logic         O_CMD_FULL,
  output logic         O_ENT_FULL,
  input  logic         I_CMD_INIT,
  input  logic         I_CMD_VALID,
  input  logic         I_CMD_ERASE,
  input  logic         I_CMD_WRITE,
  input  logic         I_CMD_READ,
  input  logic         I_CMD_SEARCH,
  input  logic         I_CMD_UPDATE,
  input  logic [127:0] I_KEY_DAT,
  input  logic [127:0] I_EKEY_MSK,
  input  logic [6:0]   I_KEY_PRI,
  input  logic [31:0]  I_KEY_VALUE
);

  localparam int IW = $clog2(ENTRIES);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic         erase;
    logic         write;
    logic         read;
    logic         search;
    logic         update;
    logic [127:0] key;
    logic [127:0] msk;
    logic [6:0]   pri;
    logic [31:0]  val;
  } cmd_t;

  // ---------------------------------------------------------------- state
  logic               ready_q;
  logic [IW-1:0]      swp_q;

  logic [ENTRIES-1:0] vld_q;
  logic [127:0]       ent_key_q [ENTRIES];
  logic [127:0]       ent_msk_q [ENTRIES];
  logic [6:0]         ent_pri_q [ENTRIES];
  logic [31:0]        ent_val_q [ENTRIES];

  cmd_t               fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        cnt_q;

  logic               ack_q, err_q, single_q, multi_q;
  logic [127:0]       rkey_q, rmsk_q;
  logic [6:0]         rpri_q;
  logic [31:0]        rval_q;

  // ---------------------------------------------------------------- FIFO
  cmd_t cmd_in, head;
  logic fifo_empty, fifo_full, push, pop;

  assign cmd_in = '{erase: I_CMD_ERASE, write: I_CMD_WRITE, read: I_CMD_READ,
                    search: I_CMD_SEARCH, update: I_CMD_UPDATE,
                    key: I_KEY_DAT, msk: I_EKEY_MSK, pri: I_KEY_PRI,
                    val: I_KEY_VALUE};
  assign head       = fifo_mem[rd_ptr_q];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  // INIT wins over everything: no pop, and the presented command is dropped.
  assign pop  = ready_q & ~fifo_empty & ~I_CMD_INIT;
  assign push = I_CMD_VALID & ~I_CMD_INIT & (~fifo_full | pop);

  // FIFO pointers and occupancy; INIT flushes.
  always_ff @(posedge I_CLK or negedge I_XRST) begin
    if (!I_XRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (I_CMD_INIT) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge I_CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= cmd_in;
  end

  // Initialisation sweep: one entry invalidated per cycle, then ready.
  always_ff @(posedge I_CLK or negedge I_XRST) begin
    if (!I_XRST) begin
      ready_q <= 1'b0;
      swp_q   <= '0;
    end else if (I_CMD_INIT) begin
      ready_q <= 1'b0;
      swp_q   <= '0;
    end else if (!ready_q) begin
      swp_q <= swp_q + IW'(1);
      if (swp_q == IW'(ENTRIES - 1)) ready_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- lookup
  logic [ENTRIES-1:0] ex_hit, tn_hit;

  // Per-entry exact and ternary match against the FIFO head.
  always_comb begin
    ex_hit = '0;
    tn_hit = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ex_hit[i] = vld_q[i] && (ent_key_q[i] == head.key) && (ent_msk_q[i] == head.msk);
      tn_hit[i] = vld_q[i] &&
                  ~|((ent_key_q[i] ^ head.key) & ~ent_msk_q[i] & ~head.msk);
    end
  end

  logic [IW-1:0] ex_idx, tn_idx, fr_idx;
  logic [IW:0]   ex_cnt, tn_cnt;
  logic          ex_fnd, tn_fnd, fr_any;
  logic [6:0]    ex_bp, tn_bp;

  // Winner select (lowest priority value, strict < keeps lowest index on
  // ties), match counts, and lowest free slot.
  always_comb begin
    ex_idx = '0; ex_cnt = '0; ex_fnd = 1'b0; ex_bp = '0;
    tn_idx = '0; tn_cnt = '0; tn_fnd = 1'b0; tn_bp = '0;
    fr_idx = '0; fr_any = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ex_hit[i]) begin
        ex_cnt = ex_cnt + (IW+1)'(1);
        if (!ex_fnd || ent_pri_q[i] < ex_bp) begin
          ex_idx = IW'(i); ex_bp = ent_pri_q[i]; ex_fnd = 1'b1;
        end
      end
      if (tn_hit[i]) begin
        tn_cnt = tn_cnt + (IW+1)'(1);
        if (!tn_fnd || ent_pri_q[i] < tn_bp) begin
          tn_idx = IW'(i); tn_bp = ent_pri_q[i]; tn_fnd = 1'b1;
        end
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        fr_idx = IW'(i); fr_any = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- execute
  logic          res_err_d, res_single_d, res_multi_d;
  logic [127:0]  res_key_d, res_msk_d;
  logic [6:0]    res_pri_d;
  logic [31:0]   res_val_d;
  logic          we_d, inv_d;
  logic [IW-1:0] we_idx_d, inv_idx_d;
  logic          ex_single, ex_multi;

  assign ex_single = (ex_cnt == (IW+1)'(1));
  assign ex_multi  = (ex_cnt >  (IW+1)'(1));

  // Opcode decode and result/side-effect generation for the FIFO head.
  always_comb begin
    res_err_d = 1'b0; res_single_d = 1'b0; res_multi_d = 1'b0;
    res_key_d = '0;   res_msk_d    = '0;   res_pri_d   = '0;  res_val_d = '0;
    we_d = 1'b0; we_idx_d = '0; inv_d = 1'b0; inv_idx_d = '0;
    if (head.erase) begin
      if (ex_fnd) begin
        inv_d = 1'b1; inv_idx_d = ex_idx;
        res_single_d = ex_single; res_multi_d = ex_multi;
        res_key_d = ent_key_q[ex_idx]; res_msk_d = ent_msk_q[ex_idx];
        res_pri_d = ent_pri_q[ex_idx]; res_val_d = ent_val_q[ex_idx];
      end else begin
        res_err_d = 1'b1;
      end
    end else if (head.write || (head.update && !ex_fnd)) begin
      // WRITE, and UPDATE that misses, both act as an insert.
      if (ex_fnd && head.write) begin
        res_err_d = 1'b1;
        res_single_d = ex_single; res_multi_d = ex_multi;
        res_key_d = ent_key_q[ex_idx]; res_msk_d = ent_msk_q[ex_idx];
        res_pri_d = ent_pri_q[ex_idx]; res_val_d = ent_val_q[ex_idx];
      end else if (fr_any) begin
        we_d = 1'b1; we_idx_d = fr_idx;
        res_key_d = head.key; res_msk_d = head.msk;
        res_pri_d = head.pri; res_val_d = head.val;
      end else begin
        res_err_d = 1'b1;
      end
    end else if (head.read) begin
      if (ex_fnd) begin
        res_single_d = ex_single; res_multi_d = ex_multi;
        res_key_d = ent_key_q[ex_idx]; res_msk_d = ent_msk_q[ex_idx];
        res_pri_d = ent_pri_q[ex_idx]; res_val_d = ent_val_q[ex_idx];
      end else begin
        res_err_d = 1'b1;
      end
    end else if (head.update) begin
      // Exact hit: key/mask are identical, so rewriting all fields only
      // changes priority and value.
      we_d = 1'b1; we_idx_d = ex_idx;
      res_single_d = 1'b1;
      res_key_d = head.key; res_msk_d = head.msk;
      res_pri_d = head.pri; res_val_d = head.val;
    end else if (head.search) begin
      if (tn_fnd) begin
        res_single_d = (tn_cnt == (IW+1)'(1));
        res_multi_d  = (tn_cnt >  (IW+1)'(1));
        res_key_d = ent_key_q[tn_idx]; res_msk_d = ent_msk_q[tn_idx];
        res_pri_d = ent_pri_q[tn_idx]; res_val_d = ent_val_q[tn_idx];
      end
    end else begin
      res_err_d = 1'b1;
    end
  end

  // Entry storage: sweep invalidation before ready, command effects after.
  always_ff @(posedge I_CLK or negedge I_XRST) begin
    if (!I_XRST) begin
      vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_key_q[i] <= '0;
        ent_msk_q[i] <= '0;
        ent_pri_q[i] <= '0;
        ent_val_q[i] <= '0;
      end
    end else if (!ready_q) begin
      vld_q[swp_q] <= 1'b0;
    end else if (pop && we_d) begin
      vld_q[we_idx_d]     <= 1'b1;
      ent_key_q[we_idx_d] <= head.key;
      ent_msk_q[we_idx_d] <= head.msk;
      ent_pri_q[we_idx_d] <= head.pri;
      ent_val_q[we_idx_d] <= head.val;
    end else if (pop && inv_d) begin
      vld_q[inv_idx_d] <= 1'b0;
    end
  end

  // Registered results; data and flags hold between ACKs.
  always_ff @(posedge I_CLK or negedge I_XRST) begin
    if (!I_XRST) begin
      ack_q <= 1'b0; err_q <= 1'b0; single_q <= 1'b0; multi_q <= 1'b0;
      rkey_q <= '0; rmsk_q <= '0; rpri_q <= '0; rval_q <= '0;
    end else begin
      ack_q <= pop;
      if (pop) begin
        err_q    <= res_err_d;
        single_q <= res_single_d;
        multi_q  <= res_multi_d;
        rkey_q   <= res_key_d;
        rmsk_q   <= res_msk_d;
        rpri_q   <= res_pri_d;
        rval_q   <= res_val_d;
      end
    end
  end

  assign O_VERSION    = VERSION;
  assign O_READY      = ready_q;
  assign O_WAIT       = ~ready_q;
  assign O_ACK        = ack_q;
  assign O_ENT_ERR    = err_q;
  assign O_SINGLE_HIT = single_q;
  assign O_MULTIL_HIT = multi_q;
  assign O_KEY_DAT    = rkey_q;
  assign O_EKEY_MSK   = rmsk_q;
  assign O_KEY_PRI    = rpri_q;
  assign O_KEY_VALUE  = rval_q;
  assign O_CMD_EMPTY  = fifo_empty;
  assign O_CMD_FULL   = fifo_full;
  assign O_ENT_FULL   = &vld_q;

endmodule

// File: tb/tb_axonerve_kvs_kernel_core.sv
// Directed bench for the KVS core: expectations are queued when a command is
// driven and compared, with timing, when its ACK appears.
module tb_axonerve_kvs_kernel_core;

  localparam int ENTRIES = 16;
  localparam int FDEPTH  = 8;

  localparam logic [4:0] OP_E = 5'b10000;
  localparam logic [4:0] OP_W = 5'b01000;
  localparam logic [4:0] OP_R = 5'b00100;
  localparam logic [4:0] OP_U = 5'b00010;
  localparam logic [4:0] OP_S = 5'b00001;

  localparam logic [127:0] KA = 128'habadcafe_abadcafe_abadcafe_abadcafe;
  localparam logic [127:0] KD = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
  localparam logic [127:0] KZ = 128'h0;

  logic         I_CLK = 1'b0, I_XRST = 1'b0;
  logic [31:0]  O_VERSION;
  logic         O_READY, O_WAIT, O_ACK, O_ENT_ERR, O_SINGLE_HIT, O_MULTIL_HIT;
  logic [127:0] O_KEY_DAT, O_EKEY_MSK;
  logic [6:0]   O_KEY_PRI;
  logic [31:0]  O_KEY_VALUE;
  logic         O_CMD_EMPTY, O_CMD_FULL, O_ENT_FULL;
  logic         I_CMD_INIT = 1'b0, I_CMD_VALID = 1'b0;
  logic         I_CMD_ERASE = 1'b0, I_CMD_WRITE = 1'b0, I_CMD_READ = 1'b0;
  logic         I_CMD_SEARCH = 1'b0, I_CMD_UPDATE = 1'b0;
  logic [127:0] I_KEY_DAT = '0, I_EKEY_MSK = '0;
  logic [6:0]   I_KEY_PRI = '0;
  logic [31:0]  I_KEY_VALUE = '0;

  axonerve_kvs_kernel_core #(.ENTRIES(ENTRIES), .FIFO_DEPTH(FDEPTH)) dut (
    .I_CLK(I_CLK), .I_XRST(I_XRST), .O_VERSION(O_VERSION), .O_READY(O_READY),
    .O_WAIT(O_WAIT), .O_ACK(O_ACK), .O_ENT_ERR(O_ENT_ERR),
    .O_SINGLE_HIT(O_SINGLE_HIT), .O_MULTIL_HIT(O_MULTIL_HIT),
    .O_KEY_DAT(O_KEY_DAT), .O_EKEY_MSK(O_EKEY_MSK), .O_KEY_PRI(O_KEY_PRI),
    .O_KEY_VALUE(O_KEY_VALUE), .O_CMD_EMPTY(O_CMD_EMPTY),
    .O_CMD_FULL(O_CMD_FULL), .O_ENT_FULL(O_ENT_FULL),
    .I_CMD_INIT(I_CMD_INIT), .I_CMD_VALID(I_CMD_VALID),
    .I_CMD_ERASE(I_CMD_ERASE), .I_CMD_WRITE(I_CMD_WRITE),
    .I_CMD_READ(I_CMD_READ), .I_CMD_SEARCH(I_CMD_SEARCH),
    .I_CMD_UPDATE(I_CMD_UPDATE), .I_KEY_DAT(I_KEY_DAT),
    .I_EKEY_MSK(I_EKEY_MSK), .I_KEY_PRI(I_KEY_PRI), .I_KEY_VALUE(I_KEY_VALUE)
  );

  typedef struct {
    string       tag;
    bit          err;
    bit          cf;
    bit          single;
    bit          multi;
    logic [31:0] val;
    int          pri;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, acks = 0, sent = 0;

  initial forever #5 I_CLK = ~I_CLK;
  initial forever begin
    @(posedge I_CLK);
    cyc++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ACK pops one expectation, including its arrival cycle.
  initial forever begin
    @(negedge I_CLK);
    if (I_XRST && O_ACK) begin
      exp_t e;
      acks++;
      if (q.size() == 0) begin
        chk("sb_nonempty", 128'(q.size()), 128'(1));
      end else begin
        e = q.pop_front();
        chk({e.tag, "_err"}, O_ENT_ERR, e.err);
        chk({e.tag, "_val"}, O_KEY_VALUE, e.val);
        chk({e.tag, "_cyc"}, 128'(cyc), 128'(e.cyc));
        if (e.cf) begin
          chk({e.tag, "_single"}, O_SINGLE_HIT, e.single);
          chk({e.tag, "_multi"}, O_MULTIL_HIT, e.multi);
        end
        if (e.pri >= 0) chk({e.tag, "_pri"}, O_KEY_PRI, 128'(e.pri));
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic [127:0] k, input logic [127:0] m,
                       input logic [6:0] p, input logic [31:0] v);
    I_CMD_ERASE  = op[4]; I_CMD_WRITE = op[3]; I_CMD_READ = op[2];
    I_CMD_UPDATE = op[1]; I_CMD_SEARCH = op[0];
    I_KEY_DAT = k; I_EKEY_MSK = m; I_KEY_PRI = p; I_KEY_VALUE = v;
    I_CMD_VALID = 1'b1;
    @(negedge I_CLK);
    I_CMD_VALID = 1'b0;
  endtask

  // Drive one command and queue its expected ACK (two edges later).
  task automatic send(input string tag, input logic [4:0] op, input logic [127:0] k,
                      input logic [127:0] m, input logic [6:0] p, input logic [31:0] v,
                      input bit e, input bit cf, input bit s, input bit mu,
                      input logic [31:0] ev, input int ep);
    exp_t x;
    x.tag = tag; x.err = e; x.cf = cf; x.single = s; x.multi = mu;
    x.val = ev; x.pri = ep; x.cyc = cyc + 2;
    q.push_back(x);
    sent++;
    drive(op, k, m, p, v);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge I_CLK);
    @(negedge I_CLK);
    chk({tag, "_drained"}, 128'(q.size()), 128'(0));
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (!O_READY && n < 100) begin
      @(posedge I_CLK);
      #1;
      n++;
    end
    @(negedge I_CLK);
    chk({tag, "_ready"}, O_READY, 1'b1);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge I_CLK);
    chk("rst_empty", O_CMD_EMPTY, 1'b1);
    chk("rst_wait", O_WAIT, 1'b1);
    chk("rst_ready", O_READY, 1'b0);
    chk("rst_ack", O_ACK, 1'b0);
    chk("rst_full", {O_CMD_FULL, O_ENT_FULL, O_ENT_ERR, O_SINGLE_HIT, O_MULTIL_HIT}, 5'b0);
    chk("rst_val", O_KEY_VALUE, 32'h0);
    chk("version", O_VERSION, 32'h0001_0000);

    // Sweep length
    I_XRST = 1'b1;
    wait_ready("sweep", n);
    chk("sweep_len", 128'(n), 128'(ENTRIES));
    chk("sweep_wait", O_WAIT, 1'b0);
    chk("sweep_empty", O_CMD_EMPTY, 1'b1);

    // Back-to-back stream
    send("w_A",  OP_W, KA, KZ, 0, 32'h34343434, 0, 0, 0, 0, 32'h34343434, -1);
    send("s_A1", OP_S, KA, KZ, 0, 0,            0, 1, 1, 0, 32'h34343434, -1);
    send("w_D",  OP_W, KD, KZ, 0, 32'ha5a5a5a5, 0, 0, 0, 0, 32'ha5a5a5a5, -1);
    send("s_A2", OP_S, KA, KZ, 0, 0,            0, 1, 1, 0, 32'h34343434, -1);
    send("s_D1", OP_S, KD, KZ, 0, 0,            0, 1, 1, 0, 32'ha5a5a5a5, -1);
    send("u_A",  OP_U, KA, KZ, 0, 32'hfefefefe, 0, 1, 1, 0, 32'hfefefefe, -1);
    send("s_A3", OP_S, KA, KZ, 0, 0,            0, 1, 1, 0, 32'hfefefefe, -1);
    send("e_A",  OP_E, KA, KZ, 0, 0,            0, 1, 1, 0, 32'hfefefefe, -1);
    send("e_0",  OP_E, KZ, KZ, 0, 0,            1, 0, 0, 0, 32'h0,        -1);
    send("s_A4", OP_S, KA, KZ, 0, 0,            0, 1, 0, 0, 32'h0,        -1);
    send("s_D2", OP_S, KD, KZ, 0, 0,            0, 1, 1, 0, 32'ha5a5a5a5, -1);
    send("e_D1", OP_E, KD, KZ, 0, 0,            0, 1, 1, 0, 32'ha5a5a5a5, -1);
    send("e_D2", OP_E, KD, KZ, 0, 0,            1, 0, 0, 0, 32'h0,        -1);
    send("s_D3", OP_S, KD, KZ, 0, 0,            0, 1, 0, 0, 32'h0,        -1);
    send("u_D1", OP_U, KD, KZ, 0, 32'h5a5a5a5a, 0, 0, 0, 0, 32'h5a5a5a5a, -1);
    send("s_D4", OP_S, KD, KZ, 0, 0,            0, 1, 1, 0, 32'h5a5a5a5a, -1);
    send("u_D2", OP_U, KD, KZ, 0, 32'h6b6b6b6b, 0, 1, 1, 0, 32'h6b6b6b6b, -1);
    send("s_D5", OP_S, KD, KZ, 0, 0,            0, 1, 1, 0, 32'h6b6b6b6b, -1);
    send("r_D",  OP_R, KD, KZ, 0, 0,            0, 1, 1, 0, 32'h6b6b6b6b, -1);
    drain("stream");
    chk("stream_acks", 128'(acks), 128'(19));

    // Ternary multi-hit, priority winner and tie to lowest index
    send("t1", OP_W, 128'h100, 128'hff,        5, 32'h11111111, 0, 0, 0, 0, 32'h11111111, 5);
    send("t2", OP_W, 128'h0,   128'hfff,       2, 32'h22222222, 0, 0, 0, 0, 32'h22222222, 2);
    send("t3", OP_W, 128'h1234,128'hffff,      9, 32'h33333333, 0, 0, 0, 0, 32'h33333333, 9);
    send("t4", OP_W, 128'h0,   128'hffff_ffff, 2, 32'h44444444, 0, 0, 0, 0, 32'h44444444, 2);
    send("t_srch", OP_S, 128'h1ab, KZ, 0, 0,   0, 1, 0, 1, 32'h22222222, 2);
    send("t_w_dup", OP_W, 128'h0, 128'hfff, 7, 32'h99,   1, 1, 1, 0, 32'h22222222, 2);
    send("no_op", 5'b00000, KD, KZ, 0, 0,      1, 1, 0, 0, 32'h0, -1);

    // Fill the remaining slots, then overflow
    for (int i = 0; i < ENTRIES - 5; i++)
      send("fill", OP_W, 128'h1_0000_0000 + 128'(i), KZ, 1, 32'h1000 + 32'(i),
           0, 0, 0, 0, 32'h1000 + 32'(i), -1);
    drain("fill");
    chk("ent_full", O_ENT_FULL, 1'b1);
    send("w_over", OP_W, 128'h7777, KZ, 0, 32'h77, 1, 0, 0, 0, 32'h0, -1);
    send("u_over", OP_U, 128'h8888, KZ, 0, 32'h88, 1, 0, 0, 0, 32'h0, -1);
    drain("over");

    // INIT: queue commands during the sweep, overfill, then flush
    I_CMD_INIT = 1'b1;
    @(negedge I_CLK);
    I_CMD_INIT = 1'b0;
    chk("init1_ready", O_READY, 1'b0);
    for (int i = 0; i < FDEPTH + 2; i++) begin
      drive(OP_W, 128'h5000 + 128'(i), KZ, 0, 32'(i));
      if (i == FDEPTH - 2) chk("fifo_not_full", O_CMD_FULL, 1'b0);
    end
    chk("fifo_full", O_CMD_FULL, 1'b1);
    chk("fifo_nempty", O_CMD_EMPTY, 1'b0);
    I_CMD_INIT = 1'b1;
    @(negedge I_CLK);
    I_CMD_INIT = 1'b0;
    chk("init2_empty", O_CMD_EMPTY, 1'b1);
    chk("init2_full", O_CMD_FULL, 1'b0);
    chk("init2_ready", O_READY, 1'b0);
    wait_ready("init2", n);
    chk("init2_entfull", O_ENT_FULL, 1'b0);
    send("s_D_init", OP_S, KD, KZ, 0, 0, 0, 1, 0, 0, 32'h0, -1);
    send("s_t2_init", OP_S, 128'h1ab, KZ, 0, 0, 0, 1, 0, 0, 32'h0, -1);
    send("w_A_init", OP_W, KA, KZ, 3, 32'h12345678, 0, 0, 0, 0, 32'h12345678, 3);
    send("r_A_init", OP_R, KA, KZ, 0, 0, 0, 1, 1, 0, 32'h12345678, 3);
    drain("final");
    repeat (4) @(negedge I_CLK);
    chk("ack_count", 128'(acks), 128'(sent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
